// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - set-associative write-through, no-write-allocate data cache.
// Define DCACHE_PERF_EN to add saturating read hit/miss counters (hit_cnt, miss_cnt).
module dcache_assoc #(
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int WORDS  = 8,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_PERF_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, WRMEM, RESP} stateT;

    stateT state;
    stateT nextState;

    logic              validMem  [WAYS][SETS];
    logic [TAG_W-1:0]  tagMem    [WAYS][SETS];
    logic [DATA_W-1:0] dataMem   [WAYS][SETS][WORDS];
    logic [WAY_W-1:0]  victimPtr [SETS];

    logic [ADDR_W-1:0] reqAddrQ;
    logic [DATA_W-1:0] reqWdataQ;
    logic [OFF_W-1:0]  beat;
    logic [WAY_W-1:0]  fillWay;
    logic              evictQ;
    logic [DATA_W-1:0] respData;

    logic [OFF_W-1:0]  reqOff;
    logic [IDX_W-1:0]  reqIdx;
    logic [TAG_W-1:0]  reqTag;
    logic [OFF_W-1:0]  lOff;
    logic [IDX_W-1:0]  lIdx;
    logic [TAG_W-1:0]  lTag;

    logic              accept;
    logic              hit;
    logic [WAY_W-1:0]  hitWay;
    logic              anyInvalid;
    logic [WAY_W-1:0]  victimWay;
    logic              fillAck;
    logic              lastBeat;

    assign reqOff = req_addr[OFF_W:1];
    assign reqIdx = req_addr[OFF_W+IDX_W:OFF_W+1];
    assign reqTag = req_addr[ADDR_W-1:OFF_W+IDX_W+1];
    assign lOff   = reqAddrQ[OFF_W:1];
    assign lIdx   = reqAddrQ[OFF_W+IDX_W:OFF_W+1];
    assign lTag   = reqAddrQ[ADDR_W-1:OFF_W+IDX_W+1];

    assign accept   = (state == IDLE) && req_valid;
    assign fillAck  = (state == FILL) && mem_ack;
    assign lastBeat = (beat == OFF_W'(WORDS - 1));

    // Fills never install a tag already present, so at most one way matches.
    always_comb begin
        hit    = 1'b0;
        hitWay = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (validMem[w][reqIdx] && (tagMem[w][reqIdx] == reqTag)) begin
                hit    = 1'b1;
                hitWay = WAY_W'(w);
            end
        end
    end

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        anyInvalid = 1'b0;
        victimWay  = victimPtr[reqIdx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!validMem[w][reqIdx]) begin
                anyInvalid = 1'b1;
                victimWay  = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_we) begin
                        nextState = WRMEM;
                    end else if (hit) begin
                        nextState = RESP;
                    end else begin
                        nextState = FILL;
                    end
                end
            end
            FILL: begin
                if (mem_ack && lastBeat) begin
                    nextState = RESP;
                end
            end
            WRMEM: begin
                if (mem_ack) begin
                    nextState = RESP;
                end
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_rdata = respData;
        mem_req    = (state == FILL) || (state == WRMEM);
        mem_we     = (state == WRMEM);
        mem_addr   = '0;
        mem_wdata  = '0;
        if (state == FILL) begin
            mem_addr = {lTag, lIdx, beat, 1'b0};
        end else if (state == WRMEM) begin
            mem_addr  = reqAddrQ;
            mem_wdata = reqWdataQ;
        end
    end

    // The victim keeps its valid bit during the fill; only completion installs the new tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    validMem[w][s] <= 1'b0;
                end
            end
            for (int s = 0; s < SETS; s++) begin
                victimPtr[s] <= '0;
            end
            reqAddrQ  <= '0;
            reqWdataQ <= '0;
            beat      <= '0;
            fillWay   <= '0;
            evictQ    <= 1'b0;
            respData  <= '0;
        end else begin
            if (accept) begin
                reqAddrQ  <= req_addr;
                reqWdataQ <= req_wdata;
                beat      <= '0;
                fillWay   <= victimWay;
                evictQ    <= !anyInvalid;
                if (req_we) begin
                    respData <= '0;
                end else if (hit) begin
                    respData <= dataMem[hitWay][reqIdx][reqOff];
                end
            end
            if (fillAck) begin
                beat <= beat + 1'b1;
                if (beat == lOff) begin
                    respData <= mem_rdata;
                end
                if (lastBeat) begin
                    validMem[fillWay][lIdx] <= 1'b1;
                    if (evictQ) begin
                        victimPtr[lIdx] <= (victimPtr[lIdx] == WAY_W'(WAYS - 1)) ?
                                           '0 : victimPtr[lIdx] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && hit) begin
            dataMem[hitWay][reqIdx][reqOff] <= req_wdata;
        end
        if (fillAck) begin
            dataMem[fillWay][lIdx][beat] <= mem_rdata;
            if (lastBeat) begin
                tagMem[fillWay][lIdx] <= lTag;
            end
        end
    end

`ifdef DCACHE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (accept && !req_we) begin
            if (hit) begin
                if (hit_cnt != 16'hFFFF) begin
                    hit_cnt <= hit_cnt + 16'd1;
                end
            end else if (miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
